instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Program-counter and fetch sequencer sitting directly upstream of the instruction memory.
- Drives a word address and one-shot read request into the memory and captures the returned 32-bit instruction.
- Presents each instruction with its PC to decode over a valid/ready handshake.
- Applies branch/jump redirects and raises a sticky halt after a programmed instruction count.

Parameters:
- ADDR_W, 5, word-address width; instruction memory depth is 2**ADDR_W words.
- DATA_W, 32, instruction width.
- PROG_LEN, 6, number of sequential PCs fetched before halt. PC values PROG_LEN and above are never requested.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  one-cycle read request to instruction memory
- imem_addr  output  ADDR_W  word address accompanying imem_req
- imem_rvalid  input  1  one pulse per request; returned data valid this cycle
- imem_rdata  input  DATA_W  returned instruction
- out_valid  output  1  instruction available to decode
- out_ready  input  1  decode accepts instruction
- out_instr  output  DATA_W  fetched instruction
- out_pc  output  ADDR_W  word address of out_instr
- redirect_valid  input  1  one-cycle branch/jump request from execute
- redirect_is_jump  input  1  1 = J-type, 0 = taken branch
- redirect_base  input  ADDR_W  PC of the branch/jump instruction
- redirect_imm  input  26  J target field, or branch offset in bits [15:0]
- halted  output  1  sticky: program fetch complete

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - pc=0, state=S_IDLE
  - imem_req=0, imem_addr=0
  - out_valid=0, out_instr=0, out_pc=0
  - halted=0
- All outputs are registered.
- States:
  - S_IDLE: next edge -> S_FETCH.
  - S_FETCH:
    - imem_req=1 and imem_addr=pc, exactly one cycle.
    - Next -> S_WAIT.
    - If pc>=PROG_LEN on entry, go to S_DONE instead; no request is issued.
  - S_WAIT:
    - Hold until imem_rvalid.
    - On imem_rvalid: out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+1 (mod 2**ADDR_W), -> S_HOLD.
    - Memory latency is any number of cycles >=1.
  - S_HOLD:
    - out_valid stays 1 and out_instr/out_pc stay stable until out_ready.
    - On out_valid&&out_ready: out_valid<=0; next is S_FETCH, or S_DONE if pc>=PROG_LEN.
  - S_DRAIN:
    - Wait for the in-flight imem_rvalid and discard its data; out_valid stays 0.
    - Then -> S_FETCH.
  - S_DONE:
    - halted=1, imem_req=0, out_valid=0.
    - Stays here until reset; redirects are ignored.
- Sustained throughput: one instruction per 3 cycles with 1-cycle memory and out_ready held high.
- Redirect target:
  - Jump: redirect_imm[ADDR_W-1:0].
  - Branch: redirect_base + 1 + redirect_imm[15:0], sign-extended, truncated mod 2**ADDR_W.
- Redirect has priority over every other event in the same cycle:
  - pc<=target and out_valid<=0, so any held instruction is flushed even if out_ready=1.
  - From S_IDLE/S_FETCH/S_HOLD -> S_FETCH.
  - From S_WAIT: in-flight response is owed -> S_DRAIN. If imem_rvalid arrives in the same cycle, the data is discarded and the next state is S_FETCH.
  - In S_DRAIN: pc updates, remain in S_DRAIN.
- Halt check uses the post-redirect pc: a redirect to pc>=PROG_LEN leads to S_DONE at the next fetch decision.
- Reset mid-operation aborts immediately to reset values. A memory response arriving after reset release with no request outstanding is ignored in every state except S_WAIT/S_DRAIN.
- imem_rvalid outside S_WAIT/S_DRAIN is ignored.

Decomposition:
- Shared package holds:
  - State encoding constants S_IDLE..S_DONE.
  - Opcode constants J=6'b000010, BEQ=6'b000100, ADDI=6'b001000, LW=6'b100011.
  - ADDR_W and DATA_W defaults.
- One natural sub-module: pc_target_calc, a combinational target adder (jump/branch select, sign extension, wrap).

Test Plan:
- Reset release, 1-cycle memory returning mem[k]=0x2001000k, out_ready=1 -> out_pc 0..5 delivered in order with matching data; halted=1 after out_pc=5 handshake; pc 6 is never requested.
- out_ready=0 for 5 cycles while out_valid -> out_instr/out_pc frozen, no new imem_req; release -> exactly one handshake, then the next fetch.
- Branch at redirect_base=4, offset 0x0014 -> target (4+1+20) mod 32 = 25 >= PROG_LEN -> no further imem_req, halted=1.
- Branch at redirect_base=3, offset 0xFFFD (-3) -> next imem_addr=1; jump with imem=0x2C51462 -> next imem_addr=2 (low 5 bits 00010).
- Redirect to 0 during S_WAIT with 4-cycle memory latency -> stale rdata not presented (out_valid=0), next imem_req addr=0 only after the stale rvalid; redirect coincident with rvalid -> data dropped.
- rst_n low mid-S_HOLD -> out_valid=0, halted=0, imem_req=0 immediately; after release the first request is to addr 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared states, opcodes and width defaults for the fetch unit
package instr_fetch_unit_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;

endpackage

// File: rtl/instr_fetch_unit_pc_target_calc.sv
// rtl/instr_fetch_unit_pc_target_calc.sv - combinational jump/branch target adder
module pc_target_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_is_jump,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [25:0]       i_imm,
  output logic [ADDR_W-1:0] o_target
);

  logic [31:0]        w_sext;
  logic [31:0]        w_sel;
  logic [31-ADDR_W:0] w_unused_hi;

  // Jump takes the raw target field; branch is base+1 plus the signed 16-bit offset.
  // Both are formed at 32 bits and the low ADDR_W bits give the wrap-around.
  always_comb begin
    w_sext      = {{16{i_imm[15]}}, i_imm[15:0]};
    w_sel       = i_is_jump ? {6'b0, i_imm} : (32'(i_base) + 32'd1 + w_sext);
    o_target    = w_sel[ADDR_W-1:0];
    w_unused_hi = w_sel[31:ADDR_W];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter and fetch sequencer in front of instruction memory
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PROG_LEN = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic              redirect_is_jump,
  input  logic [ADDR_W-1:0] redirect_base,
  input  logic [25:0]       redirect_imm,
  output logic              halted
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_imem_req;
  logic [ADDR_W-1:0] r_imem_addr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_instr;
  logic [ADDR_W-1:0] r_out_pc;
  logic              r_halted;

  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_dec_pc;
  logic              w_redirect;
  logic              w_rsp_owed;
  logic              w_decide;
  logic              w_dec_done;

  pc_target_calc #(
    .ADDR_W(ADDR_W)
  ) u_target (
    .i_is_jump(redirect_is_jump),
    .i_base   (redirect_base),
    .i_imm    (redirect_imm),
    .o_target (w_target)
  );

  // Fetch decision: is this edge the point where the next fetch (or halt) is chosen, and with which pc
  always_comb begin
    w_decide   = 1'b0;
    w_redirect = redirect_valid && (r_state != S_DONE);
    w_rsp_owed = (r_state == S_WAIT) || (r_state == S_DRAIN);
    w_dec_pc   = w_redirect ? w_target : r_pc;
    w_dec_done = int'(w_dec_pc) >= PROG_LEN;
    if (w_redirect) begin
      // An owed response must be swallowed first unless it lands in this very cycle
      w_decide = !(w_rsp_owed && !imem_rvalid);
    end else begin
      case (r_state)
        S_IDLE:  w_decide = 1'b1;
        S_HOLD:  w_decide = r_out_valid && out_ready;
        S_DRAIN: w_decide = imem_rvalid;
        default: w_decide = 1'b0;
      endcase
    end
  end

  // Sequencer: one-shot request, capture, hold for decode, drain cancelled fetches, sticky halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_imem_req  <= 1'b0;
      r_imem_addr <= '0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_halted    <= 1'b0;
    end else begin
      r_imem_req <= 1'b0;
      if (w_decide) begin
        r_pc        <= w_dec_pc;
        r_out_valid <= 1'b0;
        if (w_dec_done) begin
          r_state  <= S_DONE;
          r_halted <= 1'b1;
        end else begin
          r_state     <= S_FETCH;
          r_imem_req  <= 1'b1;
          r_imem_addr <= w_dec_pc;
        end
      end else if (w_redirect) begin
        r_pc        <= w_target;
        r_out_valid <= 1'b0;
        r_state     <= S_DRAIN;
      end else begin
        case (r_state)
          S_FETCH: r_state <= S_WAIT;
          S_WAIT: begin
            if (imem_rvalid) begin
              r_out_instr <= imem_rdata;
              r_out_pc    <= r_pc;
              r_out_valid <= 1'b1;
              r_pc        <= r_pc + 1'b1;
              r_state     <= S_HOLD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign halted    = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PL = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          redirect_valid = 1'b0;
  logic          redirect_is_jump = 1'b0;
  logic [AW-1:0] redirect_base = '0;
  logic [25:0]   redirect_imm = '0;
  logic          halted;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .PROG_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_is_jump(redirect_is_jump),
    .redirect_base(redirect_base), .redirect_imm(redirect_imm),
    .halted(halted)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  int          mem_cnt = 0;
  logic [31:0] mem_data = '0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          cyc = 0;
  int          n_req = 0;
  int          beyond = 0;
  logic [AW-1:0] hs_pc[$];
  logic [31:0]   hs_instr[$];
  int            req_cyc[$];

  // Reference model state: what the unit must show this cycle
  bit          m_req = 0, m_valid = 0, m_halt = 0, m_out = 0, m_stale = 0, m_idle = 1;
  logic [AW-1:0] m_addr = '0, m_pc = '0, m_out_pc = '0;
  logic [31:0]   m_instr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] target(input bit jmp, input logic [AW-1:0] base, input logic [25:0] imm);
    int t;
    if (jmp) return AW'(int'(imm) % 32);
    t = int'(base) + 1 + int'($signed(imm[15:0]));
    return AW'(((t % 32) + 32) % 32);
  endfunction

  // Model advance on each edge, from the rules: request -> response -> present -> accept, redirects flush
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req = 0; m_valid = 0; m_halt = 0; m_out = 0; m_stale = 0; m_idle = 1;
      m_addr = '0; m_pc = '0; m_out_pc = '0; m_instr = '0;
    end else begin
      bit dec, rv, rd, was_req;
      dec = 0;
      was_req = m_req;
      m_req = 0;
      rv = imem_rvalid && m_out;
      rd = redirect_valid && !m_halt;
      if (m_halt) begin
      end else if (rd) begin
        m_pc = target(redirect_is_jump, redirect_base, redirect_imm);
        m_valid = 0;
        m_idle = 0;
        if (m_out && !rv) m_stale = 1;
        else begin
          m_out = 0;
          dec = 1;
        end
      end else if (m_idle) begin
        m_idle = 0;
        dec = 1;
      end else if (was_req) begin
        m_out = 1;
        m_stale = 0;
      end else if (rv) begin
        m_out = 0;
        if (m_stale) dec = 1;
        else begin
          m_valid = 1;
          m_out_pc = m_addr;
          m_instr = mem[m_addr];
          m_pc = m_addr + 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
        dec = 1;
      end
      if (dec) begin
        if (int'(m_pc) >= PL) m_halt = 1;
        else begin
          m_req = 1;
          m_addr = m_pc;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("imem_req", imem_req, m_req);
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_pc", out_pc, m_out_pc);
      chk("out_instr", out_instr, m_instr);
    end
    chk("halted", halted, m_halt);
  end

  // One cycle of stimulus: memory responder plus decode/execute side inputs
  task automatic step(input bit rd = 0, input bit jmp = 0, input logic [AW-1:0] base = '0,
                      input logic [25:0] imm = '0, input bit rdy = 1);
    @(negedge clk);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data;
      end
    end
    if (imem_req) begin
      mem_cnt  = $urandom_range(lat_max, lat_min);
      mem_data = mem[imem_addr];
      n_req++;
      req_cyc.push_back(cyc);
      if (int'(imem_addr) >= PL) beyond++;
    end
    redirect_valid   = rd && !imem_req;
    redirect_is_jump = jmp;
    redirect_base    = base;
    redirect_imm     = imm;
    out_ready        = rdy;
    if (out_valid && out_ready && !redirect_valid && !halted) begin
      hs_pc.push_back(out_pc);
      hs_instr.push_back(out_instr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    imem_rvalid = 1'b0;
    mem_cnt = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    hs_pc.delete();
    hs_instr.delete();
    req_cyc.delete();
    n_req = 0;
    beyond = 0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && !out_valid; i++) step(.rdy(0));
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40 && !imem_req; i++) step(.rdy(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base_req;
    bit saw_stale;
    for (int k = 0; k < 32; k++) mem[k] = 32'h20010000 + k;

    // Straight-line program with 1-cycle memory
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 60 && !halted; i++) step(.rdy(1));
    repeat (4) step(.rdy(1));
    chk("p1_hs_count", hs_pc.size(), 6);
    for (int k = 0; k < hs_pc.size() && k < 6; k++) begin
      chk("p1_pc", hs_pc[k], k);
      chk("p1_instr", hs_instr[k], 32'h20010000 + k);
    end
    chk("p1_halted", halted, 1);
    chk("p1_req_count", n_req, 6);
    chk("p1_beyond", beyond, 0);
    chk("p1_throughput", (req_cyc.size() >= 6) ? req_cyc[5] - req_cyc[0] : -1, 15);

    // Decode stall: held instruction frozen, no new request
    do_reset();
    wait_valid();
    chk("p2_valid", out_valid, 1);
    repeat (5) begin
      step(.rdy(0));
      chk("p2_pc_frozen", out_pc, 0);
      chk("p2_instr_frozen", out_instr, 32'h20010000);
      chk("p2_no_req", imem_req, 0);
    end
    step(.rdy(1));
    wait_req();
    chk("p2_one_hs", hs_pc.size(), 1);
    chk("p2_next_addr", imem_addr, 1);

    // Branch back, jump, branch past end
    do_reset();
    wait_valid();
    step(.rd(1), .jmp(0), .base(5'd3), .imm(26'h000FFFD), .rdy(0));
    wait_req();
    chk("p3_branch_back_addr", imem_addr, 1);
    wait_valid();
    chk("p3_branch_back_pc", out_pc, 1);
    step(.rd(1), .jmp(1), .imm(26'h2C51462), .rdy(1));
    wait_req();
    chk("p3_jump_addr", imem_addr, 2);
    wait_valid();
    base_req = n_req;
    step(.rd(1), .jmp(0), .base(5'd4), .imm(26'h0000014), .rdy(1));
    repeat (10) step(.rdy(1));
    chk("p3_halted", halted, 1);
    chk("p3_no_req_after", n_req - base_req, 0);

    // Redirect while a 4-cycle fetch is in flight, then coincident with the response
    lat_min = 4; lat_max = 4;
    do_reset();
    wait_req();
    step(.rd(1), .jmp(1), .imm(26'h0), .rdy(1));
    saw_stale = 0;
    for (int i = 0; i < 30 && !imem_req; i++) begin
      step(.rdy(1));
      if (imem_rvalid) saw_stale = 1;
      chk("p4_drain_no_valid", out_valid, 0);
    end
    chk("p4_stale_seen_first", saw_stale, 1);
    chk("p4_refetch_addr", imem_addr, 0);
    for (int i = 0; i < 10 && mem_cnt != 1; i++) step(.rdy(1));
    step(.rd(1), .jmp(1), .imm(26'h3), .rdy(1));
    step(.rdy(1));
    chk("p4_coincident_req", imem_req, 1);
    chk("p4_coincident_addr", imem_addr, 3);
    chk("p4_coincident_dropped", out_valid, 0);

    // Reset while an instruction is held
    lat_min = 1; lat_max = 1;
    do_reset();
    wait_valid();
    chk("p5_held", out_valid, 1);
    do_reset();
    wait_req();
    chk("p5_first_addr", imem_addr, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 32; k++) mem[k] = $urandom;
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit rd, jmp;
      logic [25:0] imm;
      if (halted) do_reset();
      rd  = ($urandom_range(7) == 0);
      jmp = $urandom_range(1);
      if (jmp) imm = {21'($urandom), 5'($urandom_range(7))};
      else     imm = {10'($urandom), 16'(int'($urandom_range(12)) - 6)};
      step(.rd(rd), .jmp(jmp), .base(5'($urandom_range(7))), .imm(imm), .rdy($urandom_range(2) != 0));
    end
    repeat (6) step(.rdy(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
